// File: rtl/gcore_pkg.sv
// ---------------------------------------------------------------------------
// gcore_pkg
// Shared GCore definitions: datapath width, ALU opcode constants and the
// stream checker's tracker state encoding and default sequence step.
// No ports; imported by the stream checker and its capture FIFO.
// ---------------------------------------------------------------------------
package gcore_pkg;

    // Width of the ALU/accumulator result bus that the checker observes.
    localparam int GCORE_WIDTH = 8;

    // ALU opcode constants used elsewhere in the core.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SHL  = 4'h5,
        ALU_SHR  = 4'h6,
        ALU_PASS = 4'h7
    } alu_op_e;

    // Default expected increment between consecutive captured words.
    localparam logic [GCORE_WIDTH-1:0] SC_DEFAULT_STEP = 8'h01;

    // Sequence tracker states.
    typedef enum logic [1:0] {
        TRK_UNLOCKED = 2'd0,
        TRK_SEEDED   = 2'd1,
        TRK_LOCKED   = 2'd2
    } trk_state_e;

    // Saturating increment for 8-bit event counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/stream_checker_cap_fifo.sv
// ---------------------------------------------------------------------------
// cap_fifo
// Capture FIFO for the stream checker. Power-of-two depth, pointers wrap
// naturally. A write while full is accepted only if a read is accepted in
// the same cycle; otherwise it is dropped and flagged on wr_drop_o.
//
// Ports
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   clr_i       synchronous clear, overrides write and read
//   wr_en_i     write request (capture event)
//   wr_data_i   data to write
//   wr_drop_o   write request refused because the FIFO is full
//   rd_en_i     read request; ignored while empty
//   rd_data_o   registered head data
//   rd_valid_o  one-cycle pulse marking a completed read
//   empty_o     occupancy is zero
//   full_o      occupancy equals DEPTH
//   count_o     occupancy
// ---------------------------------------------------------------------------
module cap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic                       wr_drop_o,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       rd_valid_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic             empty_w;
    logic             full_w;
    logic             rd_ok_w;
    logic             wr_ok_w;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_CNT);

    // A read frees the head slot in the same edge, so a simultaneous write
    // still fits when full. There is no bypass from write to read.
    assign rd_ok_w   = rd_en_i & ~empty_w;
    assign wr_ok_w   = wr_en_i & (~full_w | rd_ok_w);
    assign wr_drop_o = wr_en_i & full_w & ~rd_ok_w;

    // Next-state for pointers, occupancy and the read port; clear wins.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (clr_i) begin
            wptr_d    = '0;
            rptr_d    = '0;
            count_d   = '0;
            rd_data_d = '0;
        end else begin
            if (wr_ok_w) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (rd_ok_w) begin
                rptr_d     = rptr_q + 1'b1;
                rd_data_d  = mem_q[rptr_q];
                rd_valid_d = 1'b1;
            end
            if (wr_ok_w && !rd_ok_w) begin
                count_d = count_q + 1'b1;
            end else if (rd_ok_w && !wr_ok_w) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control registers; reset returns the FIFO to empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage array has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_ok_w && !clr_i) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign empty_o    = empty_w;
    assign full_o     = full_w;
    assign count_o    = count_q;

endmodule

// File: rtl/stream_checker.sv
// ---------------------------------------------------------------------------
// stream_checker
// Captures words from a producer whose strobe is asynchronous to clk,
// queues them in a capture FIFO and checks that consecutive accepted words
// advance by STEP (modulo 2^WIDTH).
//
// Ports
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   din_i       producer result bus (stable >= 3 clk after a strobe rise)
//   din_clk_i   producer strobe, asynchronous; rising edge = new word
//   clr_i       synchronous clear of tracker, FIFO and sticky flags
//   rd_en_i     pop request for the FIFO head
//   rd_data_o   registered FIFO head data
//   rd_valid_o  one-cycle pulse, rd_data_o valid
//   empty_o     FIFO empty
//   full_o      FIFO full
//   count_o     FIFO occupancy
//   locked_o    tracker is locked onto the sequence
//   err_o       sticky sequence-mismatch flag
//   ovf_o       sticky dropped-capture flag
//   err_cnt_o   saturating mismatch counter
// ---------------------------------------------------------------------------
module stream_checker
    import gcore_pkg::*;
#(
    parameter int               WIDTH = GCORE_WIDTH,
    parameter logic [WIDTH-1:0] STEP  = WIDTH'(SC_DEFAULT_STEP),
    parameter int               DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   din_clk_i,
    input  logic                   clr_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   rd_valid_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   locked_o,
    output logic                   err_o,
    output logic                   ovf_o,
    output logic [7:0]             err_cnt_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             sync3_q;
    logic             capture_w;
    logic             wr_drop_w;
    logic             cap_accept_w;
    logic             match_w;
    logic [WIDTH-1:0] expect_w;

    trk_state_e       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             ovf_q, ovf_d;

    // Two-flop synchronizer plus a delay flop for rising-edge detection.
    // clr leaves these alone: clearing them while the strobe is still high
    // would make the held level look like a fresh rising edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= din_clk_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign capture_w = sync2_q & ~sync3_q;

    cap_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr_i),
        .wr_en_i    (capture_w),
        .wr_data_i  (din_i),
        .wr_drop_o  (wr_drop_w),
        .rd_en_i    (rd_en_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .count_o    (count_o)
    );

    // Only words that actually entered the FIFO are shown to the tracker.
    assign cap_accept_w = capture_w & ~wr_drop_w;
    assign expect_w     = prev_q + STEP;
    assign match_w      = (din_i == expect_w);

    // Tracker and sticky flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= TRK_UNLOCKED;
            prev_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Tracker next state. Every accepted capture reloads prev; only a
    // mismatch while locked counts as an error.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        ovf_d     = ovf_q;
        if (clr_i) begin
            state_d   = TRK_UNLOCKED;
            prev_d    = '0;
            err_d     = 1'b0;
            err_cnt_d = 8'h00;
            ovf_d     = 1'b0;
        end else begin
            if (wr_drop_w) begin
                ovf_d = 1'b1;
            end
            if (cap_accept_w) begin
                prev_d = din_i;
                case (state_q)
                    TRK_UNLOCKED: begin
                        state_d = TRK_SEEDED;
                    end
                    TRK_SEEDED: begin
                        state_d = match_w ? TRK_LOCKED : TRK_SEEDED;
                    end
                    TRK_LOCKED: begin
                        if (!match_w) begin
                            state_d   = TRK_SEEDED;
                            err_d     = 1'b1;
                            err_cnt_d = sat_inc8(err_cnt_q);
                        end
                    end
                    default: begin
                        state_d = TRK_UNLOCKED;
                    end
                endcase
            end
        end
    end

    // Tracker outputs.
    always_comb begin
        locked_o = (state_q == TRK_LOCKED);
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_stream_checker
// Directed scenarios plus a randomized run, all compared against a queue
// based reference model of the capture FIFO and sequence tracker.
// ---------------------------------------------------------------------------
module tb_stream_checker;
    import gcore_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rstN;
    logic [7:0] din;
    logic       dinClk;
    logic       clr;
    logic       rdEn;
    logic [7:0] rdData;
    logic       rdValid;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       locked;
    logic       err;
    logic       ovf;
    logic [7:0] errCnt;

    int total = 0;
    int bad   = 0;

    // Reference model state: queue contents and sequence status.
    logic [7:0] mQueue[$];
    bit         mHaveLast;
    logic [7:0] mLast;
    bit         mLocked;
    bit         mErr;
    bit         mOvf;
    int         mErrCnt;

    stream_checker #(
        .WIDTH (8),
        .STEP  (8'h01),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .din_i      (din),
        .din_clk_i  (dinClk),
        .clr_i      (clr),
        .rd_en_i    (rdEn),
        .rd_data_o  (rdData),
        .rd_valid_o (rdValid),
        .empty_o    (empty),
        .full_o     (full),
        .count_o    (count),
        .locked_o   (locked),
        .err_o      (err),
        .ovf_o      (ovf),
        .err_cnt_o  (errCnt)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        mQueue.delete();
        mHaveLast = 0;
        mLast     = 8'h00;
        mLocked   = 0;
        mErr      = 0;
        mOvf      = 0;
        mErrCnt   = 0;
    endfunction

    // A word is kept if there is room (or a read frees room this cycle);
    // a kept word continues the sequence when it is exactly one above the
    // previous kept word, modulo 256.
    function automatic void modelCapture(input logic [7:0] v, input bit readSame);
        logic [7:0] diff;
        if (readSame && mQueue.size() > 0) begin
            void'(mQueue.pop_front());
        end else if (mQueue.size() == DEPTH) begin
            mOvf = 1;
            return;
        end
        mQueue.push_back(v);
        diff = v - mLast;
        if (!mHaveLast) begin
            mLocked = 0;
        end else if (diff == 8'h01) begin
            mLocked = 1;
        end else begin
            if (mLocked) begin
                mErr    = 1;
                mErrCnt = (mErrCnt == 255) ? 255 : mErrCnt + 1;
            end
            mLocked = 0;
        end
        mLast     = v;
        mHaveLast = 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One producer strobe; optionally holds rd_en on the capture edge and
    // returns the read port sampled just after that edge.
    task automatic applyStimulus(input logic [7:0] v, input bit readAtCapture,
                                 output logic gotValid, output logic [7:0] gotData);
        din    = v;
        dinClk = 1'b1;
        tick();
        tick();
        rdEn = readAtCapture;
        tick();
        rdEn     = 1'b0;
        gotValid = rdValid;
        gotData  = rdData;
        din      = ~v;
        repeat (3) tick();
        dinClk = 1'b0;
        repeat (3) tick();
    endtask

    task automatic strobe(input logic [7:0] v);
        logic       gv;
        logic [7:0] gd;
        applyStimulus(v, 1'b0, gv, gd);
        modelCapture(v, 1'b0);
    endtask

    task automatic pulseClr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        rstN   = 1'b0;
        din    = 8'h00;
        dinClk = 1'b0;
        clr    = 1'b0;
        rdEn   = 1'b0;
        modelReset();
        repeat (3) tick();
        total++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_fifo: count=%0d empty=%b full=%b, need 0/1/0", count, empty, full);
        end
        total++;
        if (rdValid !== 1'b0 || rdData !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_rd: valid=%b data=%h, need 0/00", rdValid, rdData);
        end
        total++;
        if (locked !== 1'b0 || err !== 1'b0 || ovf !== 1'b0 || errCnt !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_flags: locked=%b err=%b ovf=%b errCnt=%h, need all 0",
                     locked, err, ovf, errCnt);
        end
        rstN = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_sequence();
        logic [7:0] exp;
        pulseClr();
        for (int i = 1; i <= 5; i++) begin
            strobe(8'(i));
            if (i == 2) begin
                total++;
                if (locked !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL seq_lock_after_2: locked=%b, need 1", locked);
                end
            end
        end
        total++;
        if (count !== 4'd5 || err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL seq_count: count=%0d err=%b, need 5/0", count, err);
        end
        for (int i = 1; i <= 5; i++) begin
            rdEn = 1'b1;
            tick();
            rdEn = 1'b0;
            exp  = mQueue.pop_front();
            total++;
            if (rdValid !== 1'b1 || rdData !== exp || exp !== 8'(i)) begin
                bad++;
                $display("[TB] FAIL seq_read%0d: valid=%b data=%h, need 1/%h", i, rdValid, rdData, 8'(i));
            end
            tick();
        end
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        total++;
        if (rdValid !== 1'b0 || empty !== 1'b1 || count !== 4'd0) begin
            bad++;
            $display("[TB] FAIL read_empty_ignored: valid=%b empty=%b count=%0d, need 0/1/0",
                     rdValid, empty, count);
        end
    endtask

    task automatic test_mismatch();
        pulseClr();
        strobe(8'h10);
        strobe(8'h11);
        strobe(8'h13);
        total++;
        if (err !== 1'b1 || errCnt !== 8'd1 || locked !== 1'b0 || mErrCnt != 1) begin
            bad++;
            $display("[TB] FAIL mismatch_err: err=%b errCnt=%0d locked=%b, need 1/1/0", err, errCnt, locked);
        end
        total++;
        if (dut.state_q !== TRK_SEEDED || dut.prev_q !== 8'h13) begin
            bad++;
            $display("[TB] FAIL mismatch_state: state=%0d prev=%h, need SEEDED/13", dut.state_q, dut.prev_q);
        end
        strobe(8'h14);
        total++;
        if (locked !== 1'b1 || errCnt !== 8'd1) begin
            bad++;
            $display("[TB] FAIL mismatch_relock: locked=%b errCnt=%0d, need 1/1", locked, errCnt);
        end
    endtask

    task automatic test_wrap();
        pulseClr();
        strobe(8'hFE);
        strobe(8'hFF);
        strobe(8'h00);
        strobe(8'h01);
        total++;
        if (err !== 1'b0 || locked !== 1'b1 || mLocked != 1) begin
            bad++;
            $display("[TB] FAIL wrap: err=%b locked=%b, need 0/1", err, locked);
        end
    endtask

    task automatic test_overflow();
        logic       gv;
        logic [7:0] gd;
        logic [7:0] exp;
        pulseClr();
        for (int i = 0; i < 9; i++) begin
            strobe(8'h20 + 8'(i));
        end
        total++;
        if (full !== 1'b1 || ovf !== 1'b1 || count !== 4'd8) begin
            bad++;
            $display("[TB] FAIL ovf_full: full=%b ovf=%b count=%0d, need 1/1/8", full, ovf, count);
        end
        exp = mQueue[0];
        applyStimulus(8'h30, 1'b1, gv, gd);
        modelCapture(8'h30, 1'b1);
        total++;
        if (gv !== 1'b1 || gd !== exp || count !== 4'd8) begin
            bad++;
            $display("[TB] FAIL ovf_rw_same: valid=%b data=%h count=%0d, need 1/%h/8", gv, gd, count, exp);
        end
        total++;
        if (err !== 1'(mErr) || errCnt !== 8'(mErrCnt) || locked !== 1'(mLocked)) begin
            bad++;
            $display("[TB] FAIL ovf_tracker: err=%b errCnt=%0d locked=%b, need %b/%0d/%b",
                     err, errCnt, locked, mErr, mErrCnt, mLocked);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rdEn = 1'b1;
            tick();
            rdEn = 1'b0;
            exp  = mQueue.pop_front();
            total++;
            if (rdValid !== 1'b1 || rdData !== exp) begin
                bad++;
                $display("[TB] FAIL ovf_drain%0d: valid=%b data=%h, need 1/%h", i, rdValid, rdData, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        pulseClr();
        for (int i = 0; i < 4; i++) begin
            strobe(8'h40 + 8'(i));
        end
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        tick();
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        total++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || rdData !== 8'h00 || rdValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_fifo: count=%0d empty=%b full=%b data=%h valid=%b, need 0/1/0/00/0",
                     count, empty, full, rdData, rdValid);
        end
        total++;
        if (locked !== 1'b0 || err !== 1'b0 || ovf !== 1'b0 || errCnt !== 8'h00) begin
            bad++;
            $display("[TB] FAIL midreset_flags: locked=%b err=%b ovf=%b errCnt=%h, need all 0",
                     locked, err, ovf, errCnt);
        end
        tick();
        rstN = 1'b1;
        tick();
        strobe(8'h77);
        total++;
        if (count !== 4'd1 || dut.state_q !== TRK_SEEDED) begin
            bad++;
            $display("[TB] FAIL midreset_fresh: count=%0d state=%0d, need 1/SEEDED", count, dut.state_q);
        end
    endtask

    task automatic test_clr_capture();
        strobe(8'h78);
        strobe(8'h90);
        total++;
        if (errCnt !== 8'(mErrCnt) || mErrCnt != 1) begin
            bad++;
            $display("[TB] FAIL clr_setup: errCnt=%0d, need 1", errCnt);
        end
        din    = 8'h55;
        dinClk = 1'b1;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        modelReset();
        total++;
        if (count !== 4'd0 || errCnt !== 8'h00 || dut.state_q !== TRK_UNLOCKED || err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clr_capture: count=%0d errCnt=%0d state=%0d err=%b, need 0/0/UNLOCKED/0",
                     count, errCnt, dut.state_q, err);
        end
        repeat (3) tick();
        dinClk = 1'b0;
        repeat (3) tick();
        total++;
        if (count !== 4'd0) begin
            bad++;
            $display("[TB] FAIL clr_no_recapture: count=%0d, need 0", count);
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic [7:0] next;
        logic       gv;
        logic [7:0] gd;
        logic [7:0] exp;
        bit         expValid;
        bit         doRead;
        pulseClr();
        next = 8'($urandom);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 99) < 60) begin
                v = ($urandom_range(0, 99) < 75) ? next : 8'($urandom);
                next = v + 8'h01;
                doRead   = ($urandom_range(0, 99) < 20);
                expValid = doRead && (mQueue.size() > 0);
                exp      = expValid ? mQueue[0] : 8'h00;
                applyStimulus(v, doRead, gv, gd);
                modelCapture(v, doRead);
                total++;
                if (gv !== 1'(expValid) || (expValid && gd !== exp)) begin
                    bad++;
                    $display("[TB] FAIL rnd_cap_read%0d: valid=%b data=%h, need %b/%h", i, gv, gd, expValid, exp);
                end
            end else begin
                expValid = (mQueue.size() > 0);
                exp      = expValid ? mQueue.pop_front() : 8'h00;
                rdEn = 1'b1;
                tick();
                rdEn = 1'b0;
                total++;
                if (rdValid !== 1'(expValid) || (expValid && rdData !== exp)) begin
                    bad++;
                    $display("[TB] FAIL rnd_read%0d: valid=%b data=%h, need %b/%h", i, rdValid, rdData, expValid, exp);
                end
                tick();
            end
            total++;
            if (count !== 4'(mQueue.size()) || full !== 1'(mQueue.size() == DEPTH) ||
                empty !== 1'(mQueue.size() == 0) || ovf !== 1'(mOvf)) begin
                bad++;
                $display("[TB] FAIL rnd_fifo%0d: count=%0d full=%b empty=%b ovf=%b, need %0d/%b/%b/%b",
                         i, count, full, empty, ovf, mQueue.size(), mQueue.size() == DEPTH,
                         mQueue.size() == 0, mOvf);
            end
            total++;
            if (locked !== 1'(mLocked) || err !== 1'(mErr) || errCnt !== 8'(mErrCnt)) begin
                bad++;
                $display("[TB] FAIL rnd_track%0d: locked=%b err=%b errCnt=%0d, need %b/%b/%0d",
                         i, locked, err, errCnt, mLocked, mErr, mErrCnt);
            end
        end
    endtask

    // Scenarios run in order; each leaves the DUT idle for the next.
    initial begin
        test_reset();
        test_sequence();
        test_mismatch();
        test_wrap();
        test_overflow();
        test_reset_mid();
        test_clr_capture();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_checker.md
STREAM_CHECKER -- requirements
Module: stream_checker

Interface
REQ-001 Parameter WIDTH, default 8, data bus width SHALL match the ALU/accumulator result bus.
REQ-002 Parameter STEP, default 8'h01, expected increment between consecutive captured words.
REQ-003 Parameter DEPTH, default 8, capture FIFO entries; SHALL be a power of two.
REQ-004 clk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 din  input  WIDTH  producer result bus, stable for at least 3 clk cycles after each din_clk rising edge.
REQ-007 din_clk  input  1  producer strobe, asynchronous to clk; a rising edge marks a new word.
REQ-008 clr  input  1  synchronous clear of checker state, FIFO and error flags.
REQ-009 rd_en  input  1  read request for the FIFO head.
REQ-010 rd_data  output  WIDTH  registered FIFO head data.
REQ-011 rd_valid  output  1  rd_data is valid; 1-cycle pulse.
REQ-012 empty / full  output  1 each  FIFO status.
REQ-013 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-014 locked  output  1  sequence tracker is in LOCKED.
REQ-015 err  output  1  sticky sequence-mismatch flag.
REQ-016 ovf  output  1  sticky dropped-capture flag.
REQ-017 err_cnt  output  8  saturating mismatch counter.

Function
REQ-018 din_clk SHALL pass through a 2-flop synchronizer followed by a third flop; a capture event SHALL occur in the cycle where stage 2 = 1 and stage 3 = 0.
REQ-019 On a capture event, din SHALL be sampled in that same cycle (3rd clk edge after the din_clk rise), and count SHALL reflect the write one cycle later.
REQ-020 Capture while full SHALL drop the word, set ovf, and leave the FIFO and tracker unchanged.
REQ-021 rd_en with empty = 0 SHALL pop the head into rd_data with rd_valid = 1 on the next cycle; rd_en with empty = 1 SHALL be ignored, with no bypass of a same-cycle write.
REQ-022 Simultaneous capture and accepted read SHALL leave count unchanged, including when full.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; full = (count == DEPTH), empty = (count == 0).
REQ-024 Tracker states: UNLOCKED, SEEDED, LOCKED; tracker SHALL hold register prev (WIDTH bits).
REQ-025 UNLOCKED: first capture SHALL load prev, then go to SEEDED.
REQ-026 SEEDED: a capture equal to prev+STEP SHALL go to LOCKED; any other value SHALL reload prev, stay in SEEDED, and raise no error.
REQ-027 LOCKED: a mismatch SHALL set err, increment err_cnt (saturating at 8'hFF), reload prev, and go to SEEDED; a match SHALL stay in LOCKED; every capture SHALL update prev.
REQ-028 Arithmetic SHALL be modulo 2^WIDTH; 8'hFF followed by 8'h00 with STEP = 1 SHALL be a match.
REQ-029 Dropped captures (REQ-020) SHALL NOT be presented to the tracker.
REQ-030 clr SHALL take priority over capture and read in the same cycle, returning all state to reset values.

Reset
REQ-031 rst = 0 SHALL asynchronously force: state UNLOCKED, prev = 0, pointers and count = 0, empty = 1, full = 0, rd_data = 0, rd_valid = 0, locked = 0, err = 0, ovf = 0, err_cnt = 0, and all synchronizer flops = 0.
REQ-032 Reset asserted mid-operation SHALL discard FIFO contents; the first din_clk rise after release SHALL be treated as a fresh capture.

Structure
REQ-033 WIDTH, the tracker state encoding, and the default STEP SHALL live in the shared GCore package, next to the ALU opcode constants.
REQ-034 The FIFO SHALL be a separate sub-module, cap_fifo (parameters WIDTH, DEPTH); synchronizer, edge detect and tracker SHALL be in stream_checker.

Verification
REQ-035 Reset then 5 strobes with din = 01, 02, 03, 04, 05 -> locked = 1 after the 2nd capture, err = 0, count = 5, reads return 01..05 in order.
REQ-036 Locked stream 10, 11, 13 -> err = 1, err_cnt = 1, state SEEDED with prev = 13; then 14 -> locked = 1.
REQ-037 Stream FE, FF, 00, 01 with STEP = 1 -> no error, locked = 1.
REQ-038 9 strobes with no reads (DEPTH = 8) -> full = 1, ovf = 1, count = 8, 9th word absent; then read and capture in the same cycle -> count stays 8.
REQ-039 rst pulsed low between strobes while count = 3 -> all outputs at reset values immediately; next strobe -> count = 1, state SEEDED.
REQ-040 clr and a capture event in the same cycle -> count = 0, err_cnt = 0, state UNLOCKED.
